clo_clz_seq: RTL

Multi-cycle leading-ones/leading-zeros unit for the CLO/CLZ instructions in the execute stage.
- Scans the 32-bit operand MSB-first, one CHUNK_W-bit chunk per cycle, through a narrow shared leading-ones slice. This replaces a full 32-bit combinational priority chain.
- Terminates early at the first chunk that is not all ones.
- Talks to the execute stage through a start / done / ack handshake and honours pipeline flush.

---
 rtl/clo_clz_seq_pkg.sv | 14 +
 rtl/clo_clz_seq_lead_ones_slice.sv | 20 ++
 rtl/clo_clz_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/clo_clz_seq_pkg.sv
// Shared types and defaults for the sequential CLO/CLZ unit.
package clo_clz_seq_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } clo_state_t;

    localparam int CLO_CHUNK_W = 8;

endpackage

// File: rtl/clo_clz_seq_lead_ones_slice.sv
// Combinational count of consecutive ones from the MSB of a W-bit slice.
module lead_ones_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0]         chunk,
    output logic [$clog2(W):0]   n
);

    localparam int NW = $clog2(W) + 1;

    // The highest zero bit wins, since later loop iterations overwrite earlier ones.
    always_comb begin
        n = NW'(W);
        for (int i = 0; i < W; i++) begin
            if (!chunk[i])
                n = NW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/clo_clz_seq.sv
// Multi-cycle CLO/CLZ: scans the operand MSB-first, one chunk per cycle, with early exit.
module clo_clz_seq
    import clo_clz_seq_pkg::*;
#(
    parameter int CHUNK_W = CLO_CHUNK_W
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  logic  is_clz,
    input  word_t in,
    input  logic  flush,
    input  logic  ack,
    output logic  busy,
    output logic  done,
    output word_t out
);

    localparam int NCHUNK = 32 / CHUNK_W;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NW     = $clog2(CHUNK_W) + 1;

    clo_state_t          state;
    word_t               operand_q;
    logic [5:0]          count;
    logic [IW-1:0]       idx;

    logic [4:0]          shamt;
    word_t               shifted;
    logic [CHUNK_W-1:0]  chunk;
    logic [NW-1:0]       n;
    logic [5:0]          sum;
    logic                last;
    logic                accept;

    // Shift the current chunk up to the MSB so the select itself is constant.
    always_comb begin
        shamt   = 5'(int'(idx) * CHUNK_W);
        shifted = operand_q << shamt;
        chunk   = shifted[31 -: CHUNK_W];
    end

    lead_ones_slice #(.W(CHUNK_W)) u_slice (
        .chunk (chunk),
        .n     (n)
    );

    assign sum    = count + 6'(n);
    assign last   = (idx == IW'(NCHUNK - 1));
    assign accept = start & ~flush & ((state == IDLE) | ((state == DONE) & ack));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            count     <= '0;
            idx       <= '0;
            operand_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // CLZ is CLO of the inverted operand.
                        operand_q <= is_clz ? ~in : in;
                        count     <= '0;
                        idx       <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else if ((state == DONE) && ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    count <= sum;
                    if ((n != NW'(CHUNK_W)) || last) begin
                        out   <= 32'(sum);
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
